// File: rtl/soc_system_mosfet_ctrl.sv
// Avalon-MM MOSFET enable port with atomic set/clear and a safety watchdog; zero-wait reads, writes land on the sampling edge.
// The watchdog, TRIPPED lockout, registers 3-5 and irq exist only when MOSFET_CTRL_WDT_EN is defined.
module soc_system_mosfet_ctrl #(
  parameter int                 WIDTH     = 4,
  parameter int                 TIMER_W   = 32,
  parameter logic [TIMER_W-1:0] WDT_RESET = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_SET    = 3'd1;
  localparam logic [2:0] A_CLR    = 3'd2;
  localparam logic [2:0] A_LOAD   = 3'd3;
  localparam logic [2:0] A_COUNT  = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;

  logic             wr;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] out_q, out_d;
  logic             lock;
  logic             trip_evt;
  logic             unused_wdat;

  assign wr          = chipselect & ~write_n;
  assign wdat        = writedata[WIDTH-1:0];
  assign unused_wdat = ^writedata;
  assign out_port    = out_q;

  always_comb begin
    out_d = out_q;
    if (wr) begin
      case (address)
        A_DATA:  if (!lock) out_d = wdat;
        A_SET:   if (!lock) out_d = out_q | wdat;
        A_CLR:   out_d = out_q & ~wdat;
        default: ;
      endcase
    end
    if (trip_evt) out_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_q <= '0;
    else          out_q <= out_d;
  end

`ifdef MOSFET_CTRL_WDT_EN
  typedef enum logic [1:0] {IDLE, ARMED, TRIPPED} state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] load_q, load_d, cnt_q, cnt_d;
  logic               trip_q, trip_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic               reload;

  // Any register write at 0..4 reloads, using the freshly written load value.
  assign reload   = wr && (address <= A_COUNT);
  assign trip_evt = (state_q == ARMED) && (cnt_q == TIMER_W'(1)) && !reload;
  assign lock     = (state_q == TRIPPED);
  assign irq      = irq_q;

  always_comb begin
    load_d   = load_q;
    cnt_d    = cnt_q;
    trip_d   = trip_q;
    irq_en_d = irq_en_q;
    state_d  = state_q;

    if (wr && address == A_LOAD) load_d = writedata[TIMER_W-1:0];

    if (reload)                                   cnt_d = load_d;
    else if (trip_evt)                            cnt_d = '0;
    else if (state_q == ARMED && cnt_q != '0)     cnt_d = cnt_q - TIMER_W'(1);

    if (wr && address == A_STATUS) begin
      irq_en_d = writedata[1];
      if (writedata[0]) trip_d = 1'b0;
    end
    // A trip on the same edge as a W1C clear takes precedence.
    if (trip_evt) trip_d = 1'b1;

    if (trip_d)                                state_d = TRIPPED;
    else if (load_d != '0 && out_d != '0)      state_d = ARMED;
    else                                       state_d = IDLE;

    irq_d = trip_d & irq_en_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      load_q   <= WDT_RESET;
      cnt_q    <= '0;
      trip_q   <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      load_q   <= load_d;
      cnt_q    <= cnt_d;
      trip_q   <= trip_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end
`else
  assign trip_evt = 1'b0;
  assign lock     = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA, A_SET, A_CLR: readdata[WIDTH-1:0] = out_q;
`ifdef MOSFET_CTRL_WDT_EN
      A_LOAD:   readdata[TIMER_W-1:0] = load_q;
      A_COUNT:  readdata[TIMER_W-1:0] = cnt_q;
      A_STATUS: readdata[1:0]         = {irq_en_q, trip_q};
`endif
      default: ;
    endcase
  end

endmodule
